// File: rtl/approx_mul_ha_pipe.sv
// Pipelined unsigned WxW approximate multiplier built from half-adder arrays over
// partial-product row pairs; approximation type chosen per transaction.
module approx_mul_ha_cell (
    input  logic       a,
    input  logic       b,
    input  logic       en,
    input  logic [1:0] mode,
    output logic       s,
    output logic       c
);
    always_comb begin
        s = a ^ b;
        c = a & b;
        if (en) begin
            unique case (mode)
                2'd1: begin s = a | b; c = 1'b0; end
                2'd2: begin s = 1'b0;  c = a;    end
                2'd3: begin s = 1'b0;  c = 1'b0; end
                default: ;
            endcase
        end
    end
endmodule

module approx_mul_ha_pipe #(
    parameter int W = 8,
    parameter logic [(W/2)*(W-1)-1:0] APPROX_MASK = 28'h39C
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  logic [1:0]     mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p,
    output logic [1:0]     p_mode
);
    localparam int H  = W / 2;
    localparam int AW = W + 2;

    logic                   live;
    logic [2:1]             vld;
    logic                   s2_adv, s1_adv, accept;
    logic [H-1:0][W-1:1]    cs, cc;
    logic [H-1:0][AW-1:0]   arr_d, arr_q;
    logic [1:0]             mode_q;
    logic [2*W-1:0]         sum;

    assign s2_adv    = !vld[2] | out_ready;
    assign s1_adv    = s2_adv | !vld[1];
    // live holds in_ready low until the first edge after reset release
    assign in_ready  = live & s1_adv;
    assign accept    = in_valid & in_ready;
    assign out_valid = vld[2];

    for (genvar k = 0; k < H; k++) begin : g_pair
        logic [W:0]   t;
        logic [W-2:0] bv;
        for (genvar j = 1; j < W; j++) begin : g_col
            approx_mul_ha_cell u_cell (
                .a    (x[2*k] & y[j]),
                .b    (x[2*k+1] & y[j-1]),
                .en   (APPROX_MASK[k*(W-1)+j-1]),
                .mode (mode),
                .s    (cs[k][j]),
                .c    (cc[k][j])
            );
        end
        assign t        = {cc[k][W-1], cs[k], x[2*k] & y[0]};
        assign bv       = {x[2*k+1] & y[W-1], cc[k][W-2:1]};
        assign arr_d[k] = {1'b0, t} + {1'b0, bv, 2'b00};
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < H; k++)
            sum = sum + ((2*W)'(arr_q[k]) << (2*k));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live   <= 1'b0;
            vld    <= '0;
            arr_q  <= '0;
            mode_q <= '0;
            p      <= '0;
            p_mode <= '0;
        end else begin
            live <= 1'b1;
            if (s1_adv) begin
                vld[1] <= accept;
                if (accept) begin
                    arr_q  <= arr_d;
                    mode_q <= mode;
                end
            end
            if (s2_adv) begin
                vld[2] <= vld[1];
                if (vld[1]) begin
                    p      <= sum;
                    p_mode <= mode_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_approx_mul_ha_pipe.sv
// Scoreboard bench for approx_mul_ha_pipe: random and directed traffic against an
// arithmetic error-per-cell reference model.
module tb_approx_mul_ha_pipe;
    localparam int W = 8;
    localparam logic [(W/2)*(W-1)-1:0] MASK = 28'h39C;

    typedef struct packed {
        logic [2*W-1:0] p;
        logic [1:0]     m;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   x = '0;
    logic [W-1:0]   y = '0;
    logic [1:0]     mode = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] p;
    logic [1:0]     p_mode;

    int checks = 0;
    int failures = 0;
    int acc_cnt = 0;
    exp_t sb[$];

    approx_mul_ha_pipe #(.W(W), .APPROX_MASK(MASK)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .p_mode(p_mode)
    );

    always #5 clk = ~clk;

    // exact product plus the error each masked cell introduces at its weight
    function automatic logic [2*W-1:0] model(input logic [W-1:0] xa, input logic [W-1:0] ya,
                                             input logic [1:0] m);
        int acc;
        acc = int'(xa) * int'(ya);
        if (m != 0)
            for (int k = 0; k < W/2; k++)
                for (int j = 1; j < W; j++)
                    if (MASK[k*(W-1)+j-1]) begin
                        int a, b, ap;
                        a  = int'(xa[2*k] & ya[j]);
                        b  = int'(xa[2*k+1] & ya[j-1]);
                        ap = (m == 1) ? (a | b) : (m == 2) ? 2*a : 0;
                        acc += (ap - (a + b)) * (1 << (j + 2*k));
                    end
        return acc[2*W-1:0];
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // monitor: push on acceptance, pop/compare on output, watch stalls
    logic           hold_v = 1'b0;
    logic [2*W-1:0] hold_p;
    logic [1:0]     hold_m;
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                sb.push_back('{p: model(x, y, mode), m: mode});
                acc_cnt++;
            end
            if (out_valid) begin
                if (hold_v) begin
                    check("stall_hold_p", p, hold_p);
                    check("stall_hold_mode", p_mode, hold_m);
                end
                if (out_ready) begin
                    hold_v = 1'b0;
                    if (sb.size() == 0) begin
                        check("sb_unexpected_output", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("sb_p", p, e.p);
                        check("sb_mode", p_mode, e.m);
                    end
                end else begin
                    hold_v = 1'b1;
                    hold_p = p;
                    hold_m = p_mode;
                end
            end else begin
                if (hold_v) check("valid_dropped", 0, 1);
                hold_v = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        tick();
        check("drain_empty", sb.size(), 0);
    endtask

    // single transaction with latency and value check against a known constant
    task automatic directed(input logic [W-1:0] xa, input logic [W-1:0] ya,
                            input logic [1:0] m, input int req);
        out_ready = 1'b1;
        in_valid = 1'b1; x = xa; y = ya; mode = m;
        @(negedge clk);
        check("dir_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("dir_lat_not_yet", out_valid, 0);
        @(negedge clk);
        check("dir_out_valid", out_valid, 1);
        check("dir_p", p, req);
        check("dir_p_mode", p_mode, m);
        tick();
    endtask

    initial begin
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_p", p, 0);
        check("rst_p_mode", p_mode, 0);
        check("rst_in_ready", in_ready, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);
        tick();

        directed(8'd255, 8'd255, 2'd0, 65025);
        directed(8'd255, 8'd255, 2'd3, 64801);
        directed(8'd255, 8'd255, 2'd1, 64913);
        directed(8'd255, 8'd255, 2'd2, 65025);
        directed(8'd255, 8'd15,  2'd2, 3809);
        directed(8'd255, 8'd15,  2'd0, 3825);

        // back-to-back stream, alternating modes
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            x = W'($urandom); y = W'($urandom); mode = (i % 2 == 0) ? 2'd1 : 2'd3;
            @(negedge clk);
            check("stream_in_ready", in_ready, 1);
            tick();
        end
        drain();

        // backpressure: pipe fills with two, then stalls
        acc_cnt = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            x = W'($urandom); y = W'($urandom); mode = 2'($urandom);
            tick();
        end
        in_valid = 1'b0;
        check("bp_accepted", acc_cnt, 2);
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        tick();
        drain();

        // reset with two transactions in flight
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            x = W'($urandom); y = W'($urandom); mode = 2'($urandom);
            tick();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_p", p, 0);
        check("mid_rst_in_ready", in_ready, 0);
        sb.delete();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("post_rst_no_stale", out_valid, 0);

        // random traffic with random backpressure
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            x = W'($urandom); y = W'($urandom); mode = 2'($urandom);
            tick();
        end
        drain();

        // exhaustive exact-mode sweep
        out_ready = 1'b1;
        for (int xi = 0; xi < 256; xi++)
            for (int yi = 0; yi < 256; yi++) begin
                in_valid = 1'b1; x = W'(xi); y = W'(yi); mode = 2'd0;
                tick();
            end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
